// File: rtl/ascon_perm_iter_pkg.sv
// ============================================================================
// Module      : ascon_perm_iter_pkg
// Description : Shared types, constants and helpers for the iterative ASCON
//               permutation engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ascon_perm_iter_pkg;

  // Five 64-bit words. x0 sits in the most significant slice, so {x0,...,x4}
  // concatenates naturally.
  typedef logic [0:4][63:0] type_state;

  localparam int N_PA  = 12;
  localparam int CNT_W = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } type_fsm;

  // Round constant: the high nibble counts down from 0xF while the low nibble
  // counts up from 0.
  function automatic logic [7:0] round_const(input logic [CNT_W-1:0] r);
    return {4'hF - r, r};
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

`default_nettype wire

// File: rtl/ascon_perm_iter_if.sv
// ============================================================================
// Module      : ascon_perm_iter_if
// Description : Request/result bundle between the mode FSM and the
//               permutation engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ascon_perm_iter_if;
  import ascon_perm_iter_pkg::*;

  logic       start_i;
  logic       mode_i;
  type_state  state_i;
  type_state  state_o;
  logic       busy_o;
  logic       done_o;
  logic [3:0] round_o;

  modport master (
    output start_i, mode_i, state_i,
    input  state_o, busy_o, done_o, round_o
  );

  modport slave (
    input  start_i, mode_i, state_i,
    output state_o, busy_o, done_o, round_o
  );

endinterface

`default_nettype wire

// File: rtl/ascon_perm_iter_round.sv
// ============================================================================
// Module      : ascon_perm_iter_round
// Description : One combinational ASCON round: constant addition (pc),
//               bit-sliced 5-bit S-box layer (ps), linear diffusion (pl).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ascon_perm_iter_round
  import ascon_perm_iter_pkg::*;
(
  input  type_state   state_i,
  input  logic [3:0]  round_i,
  output type_state   state_o
);

  logic [63:0] w_a0, w_a1, w_a2, w_a3, w_a4;
  logic [63:0] w_b0, w_b1, w_b2, w_b3, w_b4;
  logic [63:0] w_c0, w_c1, w_c2, w_c3, w_c4;
  logic [63:0] w_d0, w_d1, w_d2, w_d3, w_d4;

  // pc: constant lands in the low byte of x2 only
  assign w_a0 = state_i[0];
  assign w_a1 = state_i[1];
  assign w_a2 = state_i[2] ^ {56'd0, round_const(round_i)};
  assign w_a3 = state_i[3];
  assign w_a4 = state_i[4];

  // ps input mixing
  assign w_b0 = w_a0 ^ w_a4;
  assign w_b1 = w_a1;
  assign w_b2 = w_a2 ^ w_a1;
  assign w_b3 = w_a3;
  assign w_b4 = w_a4 ^ w_a3;

  // ps chi-like core: x_i ^= ~x_{i+1} & x_{i+2}, all from the mixed values
  assign w_c0 = w_b0 ^ (~w_b1 & w_b2);
  assign w_c1 = w_b1 ^ (~w_b2 & w_b3);
  assign w_c2 = w_b2 ^ (~w_b3 & w_b4);
  assign w_c3 = w_b3 ^ (~w_b4 & w_b0);
  assign w_c4 = w_b4 ^ (~w_b0 & w_b1);

  // ps output mixing
  assign w_d0 = w_c0 ^ w_c4;
  assign w_d1 = w_c1 ^ w_c0;
  assign w_d2 = ~w_c2;
  assign w_d3 = w_c3 ^ w_c2;
  assign w_d4 = w_c4;

  // pl: per-word rotate-xor diffusion
  assign state_o[0] = w_d0 ^ rotr64(w_d0, 19) ^ rotr64(w_d0, 28);
  assign state_o[1] = w_d1 ^ rotr64(w_d1, 61) ^ rotr64(w_d1, 39);
  assign state_o[2] = w_d2 ^ rotr64(w_d2, 1)  ^ rotr64(w_d2, 6);
  assign state_o[3] = w_d3 ^ rotr64(w_d3, 10) ^ rotr64(w_d3, 17);
  assign state_o[4] = w_d4 ^ rotr64(w_d4, 7)  ^ rotr64(w_d4, 41);

endmodule

`default_nettype wire

// File: rtl/ascon_perm_iter.sv
// ============================================================================
// Module      : ascon_perm_iter
// Description : Iterative ASCON permutation, UNROLL rounds per clock, pa (12
//               rounds) or pb (PB_ROUNDS rounds), one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ascon_perm_iter
  import ascon_perm_iter_pkg::*;
#(
  parameter int PB_ROUNDS = 6,
  parameter int UNROLL    = 1
)(
  input  wire logic          clock_i,
  input  wire logic          resetb_i,
  ascon_perm_iter_if.slave   bus
);

  if (UNROLL < 1) begin : g_bad_unroll
    $error("ascon_perm_iter: UNROLL must be at least 1");
  end else if ((PB_ROUNDS != 6 && PB_ROUNDS != 8) ||
               (N_PA % UNROLL) != 0 || (PB_ROUNDS % UNROLL) != 0) begin : g_bad_param
    $error("ascon_perm_iter: illegal PB_ROUNDS/UNROLL combination");
  end

  localparam logic [CNT_W-1:0] C_PB_FIRST = CNT_W'(N_PA - PB_ROUNDS);
  localparam logic [CNT_W-1:0] C_STEP     = CNT_W'(UNROLL);
  localparam logic [CNT_W-1:0] C_LAST     = CNT_W'(N_PA);

  type_fsm          r_fsm, w_fsm_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  type_state        r_state, w_state_nxt;
  logic             r_done, w_done_nxt;

  type_state        w_chain [0:UNROLL];

  assign w_chain[0] = r_state;

  for (genvar k = 0; k < UNROLL; k++) begin : g_round
    ascon_perm_iter_round u_round (
      .state_i (w_chain[k]),
      .round_i (r_cnt + CNT_W'(k)),
      .state_o (w_chain[k+1])
    );
  end

  // State register: FSM, round counter, working state and done pulse
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_fsm   <= IDLE;
      r_cnt   <= '0;
      r_state <= '0;
      r_done  <= 1'b0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_cnt   <= w_cnt_nxt;
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state: load on accepted start, advance UNROLL rounds per edge in RUN
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_cnt_nxt   = r_cnt;
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_fsm)
      IDLE: begin
        if (bus.start_i) begin
          w_state_nxt = bus.state_i;
          w_cnt_nxt   = bus.mode_i ? C_PB_FIRST : '0;
          w_fsm_nxt   = RUN;
        end
      end
      RUN: begin
        w_state_nxt = w_chain[UNROLL];
        w_cnt_nxt   = r_cnt + C_STEP;
        if (r_cnt + C_STEP == C_LAST) begin
          w_fsm_nxt  = IDLE;
          w_cnt_nxt  = '0;
          w_done_nxt = 1'b1;
        end
      end
      default: begin
        w_fsm_nxt = IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  assign bus.state_o = r_state;
  assign bus.busy_o  = (r_fsm == RUN);
  assign bus.done_o  = r_done;
  assign bus.round_o = (r_fsm == RUN) ? r_cnt : 4'd0;

endmodule

`default_nettype wire
